// File: rtl/dac_sample_feeder.sv
// rtl/dac_sample_feeder.sv - paced FIFO-fed sample source for the SPI DAC output controller
//
// Purpose:
//   Buffers signed 16-bit samples in a small FIFO, converts them to 12-bit
//   offset binary and, once per SAMPLE_PERIOD cycles, issues one DAC transfer
//   over the sendSample_n / isBusy / transmitComplete handshake. Everything
//   runs in the DAC SCLK domain (CLK_71Khz), so no clock crossing is needed.
//
// Configuration macro:
//   FEEDER_UNDERRUN_HOLD_EN - when defined, an underrun keeps the previous
//   dac_sample_o (last-sample hold); otherwise an underrun outputs midscale
//   12'h800 (silence). Either way a transfer is issued and the underrun counted.
//
// Ports:
//   CLK_71Khz         in   1    DAC SCLK domain clock, posedge
//   reset_n           in   1    asynchronous, active-low reset
//   wr_en_i           in   1    write strobe, one FIFO entry per cycle high
//   wr_data_i         in   16   signed two's-complement sample
//   fifo_full_o       out  1    FIFO holds 2**FIFO_DEPTH_LOG2 entries
//   fifo_empty_o      out  1    FIFO holds no entries
//   fifo_level_o      out  N+1  current FIFO occupancy
//   dac_sample_o      out  12   to inputSample; stable from request until done
//   dac_send_n_o      out  1    to sendSample_n, active low
//   dac_busy_i        in   1    from isBusy
//   dac_done_i        in   1    from transmitComplete
//   underrun_count_o  out  16   saturating count of ticks with an empty FIFO
//   overflow_o        out  1    sticky, a write was dropped
//   missed_tick_o     out  1    sticky, a tick arrived outside IDLE
//   dac_timeout_o     out  1    sticky, the DAC did not respond in time

module dac_sample_feeder #(
  parameter int unsigned SAMPLE_PERIOD   = 32,
  parameter int unsigned FIFO_DEPTH_LOG2 = 3,
  parameter int unsigned TIMEOUT_CYCLES  = 64
) (
  input  logic                       CLK_71Khz,
  input  logic                       reset_n,
  input  logic                       wr_en_i,
  input  logic [15:0]                wr_data_i,
  output logic                       fifo_full_o,
  output logic                       fifo_empty_o,
  output logic [FIFO_DEPTH_LOG2:0]   fifo_level_o,
  output logic [11:0]                dac_sample_o,
  output logic                       dac_send_n_o,
  input  logic                       dac_busy_i,
  input  logic                       dac_done_i,
  output logic [15:0]                underrun_count_o,
  output logic                       overflow_o,
  output logic                       missed_tick_o,
  output logic                       dac_timeout_o
);

  localparam int unsigned DEPTH  = 1 << FIFO_DEPTH_LOG2;
  localparam int unsigned LVL_W  = FIFO_DEPTH_LOG2 + 1;
  localparam int unsigned TICK_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_BUSY = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [TICK_W-1:0]          tick_cnt_q, tick_cnt_d;
  logic [TO_W-1:0]            to_cnt_q, to_cnt_d;
  logic [FIFO_DEPTH_LOG2-1:0] wptr_q, wptr_d;
  logic [FIFO_DEPTH_LOG2-1:0] rptr_q, rptr_d;
  logic [LVL_W-1:0]           level_q, level_d;
  logic                       full_q, full_d;
  logic                       empty_q, empty_d;
  logic [11:0]                sample_q, sample_d;
  logic                       send_n_q, send_n_d;
  logic [15:0]                underrun_q, underrun_d;
  logic                       overflow_q, overflow_d;
  logic                       missed_q, missed_d;
  logic                       timeout_q, timeout_d;

  // Entries are stored already converted to offset binary.
  logic [11:0]                mem_q [DEPTH];

  logic                       tick;
  logic                       pop;
  logic                       push;
  logic [11:0]                wr_conv;
  logic                       unused_wr_lsbs;

  // Offset binary: keep the top 12 bits and flip the sign bit.
  assign wr_conv        = {~wr_data_i[15], wr_data_i[14:4]};
  // The four LSBs are discarded by the truncation.
  assign unused_wr_lsbs = ^wr_data_i[3:0];

  assign tick = (tick_cnt_q == TICK_W'(SAMPLE_PERIOD - 1));

  // Free-running sample-period counter.
  always_comb begin
    tick_cnt_d = tick_cnt_q + 1'b1;
    if (tick) begin
      tick_cnt_d = '0;
    end
  end

  // Transfer FSM: next state and outputs.
  always_comb begin
    state_d    = state_q;
    send_n_d   = send_n_q;
    sample_d   = sample_q;
    to_cnt_d   = to_cnt_q;
    underrun_d = underrun_q;
    timeout_d  = timeout_q;
    pop        = 1'b0;

    // A tick outside IDLE skips that period entirely; nothing is popped.
    missed_d   = missed_q | (tick && (state_q != ST_IDLE));

    case (state_q)
      ST_IDLE: begin
        to_cnt_d = '0;
        if (tick) begin
          send_n_d = 1'b0;
          state_d  = ST_WAIT_BUSY;
          if (!empty_q) begin
            pop      = 1'b1;
            sample_d = mem_q[rptr_q];
          end else begin
`ifdef FEEDER_UNDERRUN_HOLD_EN
            sample_d = sample_q;
`else
            sample_d = 12'h800;
`endif
            if (underrun_q != 16'hFFFF) begin
              underrun_d = underrun_q + 16'd1;
            end
          end
        end
      end

      ST_WAIT_BUSY: begin
        to_cnt_d = to_cnt_q + 1'b1;
        if (dac_busy_i) begin
          send_n_d = 1'b1;
          state_d  = ST_WAIT_DONE;
        end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_d = 1'b1;
          send_n_d  = 1'b1;
          state_d   = ST_IDLE;
        end
      end

      ST_WAIT_DONE: begin
        // The timeout budget covers the whole transfer, not each phase.
        to_cnt_d = to_cnt_q + 1'b1;
        if (dac_done_i) begin
          state_d = ST_IDLE;
        end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_d = 1'b1;
          send_n_d  = 1'b1;
          state_d   = ST_IDLE;
        end
      end

      default: begin
        send_n_d = 1'b1;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // FIFO bookkeeping. A write on a full FIFO is still taken when the same
  // cycle pops, because a slot frees up at that edge.
  always_comb begin
    push       = wr_en_i && (!full_q || pop);
    overflow_d = overflow_q | (wr_en_i && full_q && !pop);
    wptr_d     = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d     = pop  ? rptr_q + 1'b1 : rptr_q;
    level_d    = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    full_d  = (level_d == LVL_W'(DEPTH));
    empty_d = (level_d == '0);
  end

  always_ff @(posedge CLK_71Khz or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      tick_cnt_q <= '0;
      to_cnt_q   <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      sample_q   <= 12'h800;
      send_n_q   <= 1'b1;
      underrun_q <= '0;
      overflow_q <= 1'b0;
      missed_q   <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      to_cnt_q   <= to_cnt_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      level_q    <= level_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      sample_q   <= sample_d;
      send_n_q   <= send_n_d;
      underrun_q <= underrun_d;
      overflow_q <= overflow_d;
      missed_q   <= missed_d;
      timeout_q  <= timeout_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers and level.
  always_ff @(posedge CLK_71Khz) begin
    if (push) begin
      mem_q[wptr_q] <= wr_conv;
    end
  end

  assign fifo_full_o      = full_q;
  assign fifo_empty_o     = empty_q;
  assign fifo_level_o     = level_q;
  assign dac_sample_o     = sample_q;
  assign dac_send_n_o     = send_n_q;
  assign underrun_count_o = underrun_q;
  assign overflow_o       = overflow_q;
  assign missed_tick_o    = missed_q;
  assign dac_timeout_o    = timeout_q;

endmodule

// File: tb/tb_dac_sample_feeder.sv
// tb/tb_dac_sample_feeder.sv - scoreboard bench for dac_sample_feeder with a DAC responder model

module tb_dac_sample_feeder;

  localparam int PERIOD = 32;
  localparam int TOUT   = 64;
  localparam int DEPTH  = 8;
`ifdef FEEDER_UNDERRUN_HOLD_EN
  localparam int UNDERRUN_SAMPLE = 'hC00;
`else
  localparam int UNDERRUN_SAMPLE = 'h800;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [15:0] wr_data = 16'h0;
  logic        fifo_full, fifo_empty;
  logic [3:0]  fifo_level;
  logic [11:0] dac_sample;
  logic        dac_send_n;
  logic        dac_busy, dac_done;
  logic [15:0] underrun_count;
  logic        overflow, missed_tick, dac_timeout;

  dac_sample_feeder #(
    .SAMPLE_PERIOD  (PERIOD),
    .FIFO_DEPTH_LOG2(3),
    .TIMEOUT_CYCLES (TOUT)
  ) dut (
    .CLK_71Khz       (clk),
    .reset_n         (reset_n),
    .wr_en_i         (wr_en),
    .wr_data_i       (wr_data),
    .fifo_full_o     (fifo_full),
    .fifo_empty_o    (fifo_empty),
    .fifo_level_o    (fifo_level),
    .dac_sample_o    (dac_sample),
    .dac_send_n_o    (dac_send_n),
    .dac_busy_i      (dac_busy),
    .dac_done_i      (dac_done),
    .underrun_count_o(underrun_count),
    .overflow_o      (overflow),
    .missed_tick_o   (missed_tick),
    .dac_timeout_o   (dac_timeout)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  logic [11:0] exp_q[$];
  logic [11:0] last_exp = 12'h800;
  int          und_exp = 0;
  logic        ovf_exp = 1'b0;
  bit          dac_ok = 1'b1;
  int          n_req = 0;
  int          cyc;
  logic        prev_send = 1'b1;
  int          low_len = 0;
  int          exp_low = 2;
  int          dac_cnt;

  task automatic chk(input string nm, input int act, input int want);
    n_chk++;
    if (act != want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, want, $time);
    end
  endtask

  // Signed sample to offset binary by plain arithmetic.
  function automatic logic [11:0] conv(input logic [15:0] d);
    int v;
    v = int'($signed(d)) + 32768;
    return 12'(v >> 4);
  endfunction

  // Edges counted since reset release; ticks fall on edges k with k%PERIOD == PERIOD-1.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  // DAC controller model: sees the request one edge late, busy for 16 cycles, then done.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dac_busy <= 1'b0;
      dac_done <= 1'b0;
      dac_cnt  <= 0;
    end else begin
      dac_done <= 1'b0;
      if (dac_busy) begin
        if (dac_cnt == 15) begin
          dac_busy <= 1'b0;
          dac_done <= 1'b1;
        end
        dac_cnt <= dac_cnt + 1;
      end else if (dac_ok && !dac_send_n && !dac_done) begin
        dac_busy <= 1'b1;
        dac_cnt  <= 0;
      end
    end
  end

  // Monitor: every request pops the scoreboard; FIFO status and flags are checked each cycle.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_send = 1'b1;
      low_len   = 0;
    end else begin
      if (dac_send_n == 1'b0) begin
        if (prev_send) begin
          n_req++;
          chk("req_on_tick", cyc % PERIOD, 0);
          if (exp_q.size() > 0) begin
            last_exp = exp_q.pop_front();
          end else begin
            if (und_exp < 65535) und_exp++;
`ifndef FEEDER_UNDERRUN_HOLD_EN
            last_exp = 12'h800;
`endif
          end
          exp_low = dac_ok ? 2 : TOUT;
          low_len = 1;
        end else begin
          low_len++;
        end
      end else if (!prev_send) begin
        chk("send_n_low_len", low_len, exp_low);
      end
      prev_send = dac_send_n;
      chk("dac_sample", int'(dac_sample), int'(last_exp));
      chk("fifo_level", int'(fifo_level), exp_q.size());
      chk("fifo_empty", int'(fifo_empty), int'(exp_q.size() == 0));
      chk("fifo_full", int'(fifo_full), int'(exp_q.size() == DEPTH));
      chk("overflow", int'(overflow), int'(ovf_exp));
      chk("underrun_count", int'(underrun_count), und_exp);
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_write(input logic [15:0] d, input bit at_tick);
    bit tk;
    int g;
    @(negedge clk);
    if (at_tick) begin
      g = 0;
      while ((cyc % PERIOD != PERIOD - 1) && g < 2 * PERIOD) begin
        @(negedge clk);
        g++;
      end
    end else if (exp_q.size() == 0 && cyc % PERIOD == PERIOD - 1) begin
      @(negedge clk);
    end
    tk      = (cyc % PERIOD == PERIOD - 1);
    wr_en   = 1'b1;
    wr_data = d;
    @(posedge clk);
    if (exp_q.size() < DEPTH || (tk && exp_q.size() > 0)) exp_q.push_back(conv(d));
    else ovf_exp = 1'b1;
    #1 wr_en = 1'b0;
  endtask

  task automatic wait_req(input int target);
    int t;
    t = 0;
    while (n_req < target && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("wait_req", n_req, target);
  endtask

  task automatic wait_empty();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("wait_empty", exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int t;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_send_n", int'(dac_send_n), 1);
    chk("rst_sample", int'(dac_sample), 'h800);
    chk("rst_level", int'(fifo_level), 0);
    chk("rst_empty", int'(fifo_empty), 1);
    chk("rst_full", int'(fifo_full), 0);
    chk("rst_underrun", int'(underrun_count), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_missed", int'(missed_tick), 0);
    chk("rst_timeout", int'(dac_timeout), 0);
    reset_n = 1'b1;

    // First transfer with a compliant DAC.
    do_write(16'h7FFF, 1'b0);
    wait_req(1);
    wait_cycles(20);
    chk("first_sample", int'(dac_sample), 'hFFF);
    chk("first_empty", int'(fifo_empty), 1);

    // Conversion sweep.
    do_write(16'h0000, 1'b0);
    do_write(16'h8000, 1'b0);
    do_write(16'hFFF0, 1'b0);
    do_write(16'h1234, 1'b0);
    wait_req(5);
    wait_cycles(2);
    chk("sweep_last", int'(dac_sample), 'h923);

    // One sample then three underrun periods.
    do_write(16'h4000, 1'b0);
    wait_req(9);
    wait_cycles(2);
    chk("underrun_3", int'(underrun_count), 3);
    chk("underrun_sample", int'(dac_sample), UNDERRUN_SAMPLE);

    // Fill past capacity between ticks, then write on a full FIFO in a tick cycle.
    for (int i = 0; i < 9; i++) do_write(16'(i * 16'h1111), 1'b0);
    wait_cycles(1);
    chk("fill_level", int'(fifo_level), 8);
    chk("fill_full", int'(fifo_full), 1);
    chk("fill_overflow", int'(overflow), 1);
    do_write(16'h5555, 1'b1);
    wait_cycles(1);
    chk("tick_write_level", int'(fifo_level), 8);
    chk("tick_write_overflow", int'(overflow), 1);
    wait_empty();

    // Randomized traffic.
    repeat (40) begin
      wait_cycles($urandom_range(0, 40));
      do_write(16'($urandom), 1'b0);
    end
    wait_empty();

    // DAC hang: busy never rises.
    r = n_req;
    wait_req(r + 1);
    wait_cycles(20);
    chk("pre_hang_missed", int'(missed_tick), 0);
    chk("pre_hang_timeout", int'(dac_timeout), 0);
    dac_ok = 1'b0;
    wait_req(r + 2);
    t = 0;
    while (dac_send_n == 1'b0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("hang_send_n", int'(dac_send_n), 1);
    chk("hang_timeout", int'(dac_timeout), 1);
    chk("hang_missed", int'(missed_tick), 1);
    dac_ok = 1'b1;

    // Reset in the middle of a transfer.
    r = n_req;
    wait_req(r + 1);
    do_write(16'h2222, 1'b0);
    do_write(16'h3333, 1'b0);
    wait_cycles(3);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_send_n", int'(dac_send_n), 1);
    chk("mid_rst_sample", int'(dac_sample), 'h800);
    chk("mid_rst_level", int'(fifo_level), 0);
    chk("mid_rst_empty", int'(fifo_empty), 1);
    chk("mid_rst_overflow", int'(overflow), 0);
    chk("mid_rst_missed", int'(missed_tick), 0);
    chk("mid_rst_timeout", int'(dac_timeout), 0);
    chk("mid_rst_underrun", int'(underrun_count), 0);
    exp_q.delete();
    und_exp  = 0;
    ovf_exp  = 1'b0;
    last_exp = 12'h800;
    wait_cycles(2);
    reset_n = 1'b1;

    do_write(16'h8000, 1'b0);
    wait_req(n_req + 1);
    wait_cycles(20);
    chk("post_rst_sample", int'(dac_sample), 'h000);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/dac_sample_feeder.md
# dac_sample_feeder

Paced sample source for the SPI DAC output controller. Buffers signed 16-bit audio samples from the synthesis path in a small FIFO and converts them to 12-bit offset binary. Once per sample period it issues one DAC transfer using the controller's `sendSample_n` / `isBusy` / `transmitComplete` handshake. Runs entirely in the DAC's SCLK domain, so there is no clock crossing to the controller.

## Interface
- `SAMPLE_PERIOD`, 32: CLK_71Khz cycles per output sample (≈22.3 kHz at 714.285 kHz).
- `FIFO_DEPTH_LOG2`, 3: FIFO depth is 2**N entries (default 8).
- `TIMEOUT_CYCLES`, 64: maximum cycles spent waiting on the DAC before aborting a transfer.
- `clk`  in  1  CLK_71Khz; all logic on posedge.
- `reset_n`  in  1  asynchronous, active-low.
- `wr_en`  in  1  write strobe, one entry per cycle high.
- `wr_data`  in  16  signed two's-complement sample.
- `fifo_full`  out  1  FIFO holds 2**N entries.
- `fifo_empty`  out  1  FIFO holds 0 entries.
- `fifo_level`  out  N+1  current occupancy.
- `dac_sample`  out  12  connects to `inputSample`; held stable from request until done.
- `dac_send_n`  out  1  connects to `sendSample_n`; active low.
- `dac_busy`  in  1  from `isBusy`.
- `dac_done`  in  1  from `transmitComplete`.
- `underrun_count`  out  16  saturating count of periods with an empty FIFO.
- `overflow`  out  1  sticky; set when a write is dropped.
- `missed_tick`  out  1  sticky; set when a tick arrives while not IDLE.
- `dac_timeout`  out  1  sticky; set when the DAC fails to respond in time.

## Operation
- Reset values: FIFO empty, `fifo_level`=0, `dac_sample`=12'h800, `dac_send_n`=1, all counts and flags 0, state IDLE, tick counter 0.
- Tick counter: free-running from 0 to SAMPLE_PERIOD−1, then wraps. A tick is asserted for one cycle at the terminal count.
- Conversion: `dac_sample` = {~d[15], d[14:4]}, i.e. truncate to 12 bits and flip the MSB. Examples: 0x0000→0x800, 0x7FFF→0xFFF, 0x8000→0x000, 0xFFF0→0x7FF.
- FSM states:
  - IDLE: on tick, pop the FIFO head if non-empty and load the converted value. If the FIFO is empty, apply the underrun policy (see Configuration) and increment `underrun_count`, saturating at 0xFFFF. Drive `dac_send_n` low and go to WAIT_BUSY. A request is issued on every tick, including underrun ticks.
  - WAIT_BUSY: hold `dac_send_n` low until `dac_busy`=1, then drive `dac_send_n` high and go to WAIT_DONE.
  - WAIT_DONE: on `dac_done`=1, go to IDLE.
- Timeout: a counter runs in WAIT_BUSY and WAIT_DONE. When it reaches TIMEOUT_CYCLES: set `dac_timeout`, drive `dac_send_n`=1, go to IDLE.
- A tick in any state other than IDLE sets `missed_tick`. That sample period is skipped; no pop occurs.
- FIFO:
  - Write when full is dropped and sets `overflow`, unless a pop happens in the same cycle, in which case the write is accepted.
  - A pop from an empty FIFO never occurs.
  - A simultaneous push and pop leaves `fifo_level` unchanged.
  - Pointers wrap modulo 2**N.
- Sticky flags clear only on reset.
- Reset asserted mid-transfer: outputs return to reset values immediately. The DAC controller resets on the same `reset_n`.

## Timing
- Write to `fifo_level` update: 1 cycle.
- Tick edge T: `dac_sample` and `dac_send_n`=0 are registered at T.
- The DAC samples the request at T+1, `isBusy` is seen at T+2, and `dac_send_n` returns high at T+2. The low pulse is therefore exactly 2 cycles with a compliant DAC.
- The DAC transfer completes at about T+18, well inside SAMPLE_PERIOD=32.
- `dac_sample` is not updated outside IDLE.
- `fifo_full`, `fifo_empty` and `fifo_level` are registered.

## Configuration
- `FEEDER_UNDERRUN_HOLD_EN` defined: on underrun, `dac_sample` keeps its previous value (last-sample hold).
- Not defined: on underrun, `dac_sample` is forced to 12'h800 (midscale, silence).
- In both cases `underrun_count` increments and a DAC transfer is still issued.

## Test plan
- Reset: write 0x7FFF, wait for a tick with a DAC model attached → `dac_sample`=0xFFF, `dac_send_n` low for exactly 2 cycles, FSM back in IDLE after `dac_done`, `fifo_empty`=1.
- Conversion sweep: write 0x0000, 0x8000, 0xFFF0, 0x1234 → successive ticks present 0x800, 0x000, 0x7FF, 0x923, spaced exactly 32 cycles apart.
- Fill and overflow: write 9 entries back-to-back with no tick → `fifo_level`=8, `fifo_full`=1, `overflow`=1. Write on the full FIFO in a tick cycle → accepted, level stays 8, `overflow` unchanged.
- Underrun: leave the FIFO empty for 3 ticks after sample 0x4000 (→0xC00) → `underrun_count`=3. `dac_sample`=0xC00 with HOLD_EN defined, 0x800 without.
- DAC hang: tie `dac_busy`=0 → `dac_timeout` set 64 cycles after the request, `dac_send_n` high. The next tick lands in WAIT_BUSY → `missed_tick`=1.
- Reset mid-transfer: assert `reset_n` in WAIT_DONE → `dac_send_n`=1, `dac_sample`=0x800, `fifo_level`=0, all flags 0 asynchronously.
